// File: rtl/gtp_frame_pkg.sv
// gtp_frame_pkg: K/D characters, link words and framer types
// shared by the GTP lane-0 frame transmitter.
package gtp_frame_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] D21_5 = 8'hB5;

  localparam logic [15:0] IDLE_WORD = {D21_5, K28_5};
  localparam logic [1:0]  K_LOW     = 2'b01;
  localparam logic [1:0]  K_NONE    = 2'b00;

`ifdef GTP_FRAME_CSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_DATA,
    ST_CSUM,
    ST_EOF
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_DATA,
    ST_EOF
  } state_t;
`endif

  typedef struct packed {
    logic        last;
    logic [15:0] data;
  } fifo_word_t;

endpackage

// File: rtl/gtp_tx_fifo.sv
// gtp_tx_fifo: 2**AW x 17 synchronous FIFO with registered read,
// full/empty flags; synchronous reset flushes the pointers.
module gtp_tx_fifo
  import gtp_frame_pkg::*;
#(
  parameter int AW = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  fifo_word_t wr_data,
  input  logic       rd_en,
  output fifo_word_t rd_data,
  output logic       full,
  output logic       empty
);

  localparam int DEPTH = 2 ** AW;

  fifo_word_t mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        do_wr;
  logic        do_rd;

  assign full  = (wptr ^ rptr) == {1'b1, {AW{1'b0}}};
  assign empty = wptr == rptr;
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) wptr <= wptr + (AW+1)'(1);
      if (do_rd) begin
        rd_data <= mem[rptr[AW-1:0]];
        rptr    <= rptr + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/gtp_frame_tx.sv
// gtp_frame_tx: buffers sample frames and emits K-delimited frames
// on GTP lane 0; define GTP_FRAME_CSUM_EN to append a checksum word.
module gtp_frame_tx
  import gtp_frame_pkg::*;
#(
  parameter int AW        = 6,
  parameter int MAX_WORDS = 60,
  parameter int IDLE_GAP  = 4
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic [1:0]  chan_id,
  input  logic        gtp_ready,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [15:0] tx_data,
  output logic [1:0]  tx_charisk,
  output logic [15:0] frames_sent,
  output logic [7:0]  trunc_cnt
);

  localparam int WCW = $clog2(MAX_WORDS + 1);

  fifo_word_t     wr_word;
  fifo_word_t     rd_word;
  logic           fifo_full;
  logic           fifo_empty;
  logic           wr_en;
  logic           rd_en;
  logic           rd_req;
  logic           accept;
  logic           at_max;
  logic           discard;
  logic [WCW-1:0] wcnt;
  logic [AW:0]    pending;
  logic           inc;
  logic           dec;

  state_t         state;
  state_t         state_n;
  logic [15:0]    word_n;
  logic [1:0]     k_n;
  logic           load;
  logic           done;
  logic           start;
  logic [5:0]     seq;
  logic [3:0]     gap;
  logic [7:0]     len;
  logic           dlast;
`ifdef GTP_FRAME_CSUM_EN
  logic [15:0]    csum;
`endif

  assign s_ready = ~fifo_full & ~wb_rst;
  assign accept  = s_valid & s_ready;
  assign at_max  = wcnt == WCW'(MAX_WORDS - 1);
  assign wr_en   = accept & ~discard;
  assign wr_word = '{last: s_last | at_max, data: s_data};
  assign rd_en   = rd_req & ~fifo_empty;

  gtp_tx_fifo #(
    .AW(AW)
  ) u_fifo (
    .clk     (wb_clk),
    .rst     (wb_rst),
    .wr_en   (wr_en),
    .wr_data (wr_word),
    .rd_en   (rd_en),
    .rd_data (rd_word),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Overlong frames are closed at MAX_WORDS; the tail is dropped.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      wcnt      <= '0;
      discard   <= 1'b0;
      trunc_cnt <= '0;
    end else if (accept) begin
      if (discard) begin
        if (s_last) discard <= 1'b0;
      end else if (s_last | at_max) begin
        wcnt <= '0;
        if (!s_last) begin
          discard <= 1'b1;
          if (trunc_cnt != 8'hFF) trunc_cnt <= trunc_cnt + 8'd1;
        end
      end else begin
        wcnt <= wcnt + WCW'(1);
      end
    end
  end

  assign inc = wr_en & wr_word.last;
  assign dec = load & rd_word.last;

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      pending <= '0;
    end else if (inc & ~dec) begin
      pending <= pending + (AW+1)'(1);
    end else if (dec & ~inc) begin
      pending <= pending - (AW+1)'(1);
    end
  end

  assign start = (pending != '0) & gtp_ready & (gap == 4'd0);

  // Next state and next link word; the registers below publish both.
  always_comb begin
    state_n = state;
    word_n  = IDLE_WORD;
    k_n     = K_LOW;
    rd_req  = 1'b0;
    load    = 1'b0;
    done    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_SOF;
          word_n  = {chan_id, seq, K27_7};
          rd_req  = 1'b1;
        end
      end
      ST_SOF, ST_DATA: begin
        if (state == ST_DATA && dlast) begin
`ifdef GTP_FRAME_CSUM_EN
          state_n = ST_CSUM;
          word_n  = ~csum;
          k_n     = K_NONE;
`else
          state_n = ST_EOF;
          word_n  = {len, K29_7};
`endif
        end else begin
          state_n = ST_DATA;
          word_n  = rd_word.data;
          k_n     = K_NONE;
          load    = 1'b1;
          rd_req  = ~rd_word.last;
        end
      end
`ifdef GTP_FRAME_CSUM_EN
      ST_CSUM: begin
        state_n = ST_EOF;
        word_n  = {len, K29_7};
      end
`endif
      ST_EOF: begin
        state_n = ST_IDLE;
        done    = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state       <= ST_IDLE;
      tx_data     <= IDLE_WORD;
      tx_charisk  <= K_LOW;
      seq         <= '0;
      frames_sent <= '0;
      gap         <= '0;
      len         <= '0;
      dlast       <= 1'b0;
    end else begin
      state      <= state_n;
      tx_data    <= word_n;
      tx_charisk <= k_n;
      if (load) begin
        dlast <= rd_word.last;
        len   <= (state == ST_SOF) ? 8'd1 : len + 8'd1;
      end
      if (done) begin
        gap         <= 4'(IDLE_GAP);
        seq         <= seq + 6'd1;
        frames_sent <= frames_sent + 16'd1;
      end else if (state == ST_IDLE && gap != 4'd0) begin
        gap <= gap - 4'd1;
      end
    end
  end

`ifdef GTP_FRAME_CSUM_EN
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      csum <= '0;
    end else if (load) begin
      csum <= ((state == ST_SOF) ? 16'd0 : csum) + rd_word.data;
    end
  end
`endif

endmodule

// File: tb/tb_gtp_frame_tx.sv
// tb_gtp_frame_tx: random and directed frames against a queue-based
// link model; every cycle of tx output is checked against it.
module tb_gtp_frame_tx;

  localparam int GAP  = 4;
  localparam int MAXW = 60;
`ifdef GTP_FRAME_CSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  typedef struct packed {
    logic        eof;
    logic [1:0]  k;
    logic [15:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  chan_id = 2'd0;
  logic        gtp_ready = 1'b1;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [15:0] tx_data;
  logic [1:0]  tx_charisk;
  logic [15:0] frames_sent;
  logic [7:0]  trunc_cnt;

  gtp_frame_tx dut (
    .wb_clk      (clk),
    .wb_rst      (rst),
    .chan_id     (chan_id),
    .gtp_ready   (gtp_ready),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .tx_data     (tx_data),
    .tx_charisk  (tx_charisk),
    .frames_sent (frames_sent),
    .trunc_cnt   (trunc_cnt)
  );

  always #4 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          idle_run = 0;
  int          sof_cyc = 0;
  int          last_cyc = 0;
  int          acc_total = 0;
  bit          rst_pend = 1'b1;
  bit          in_frame = 1'b0;
  bit          fresh = 1'b1;
  bit          discarding = 1'b0;
  logic [5:0]  m_seq = '0;
  logic [7:0]  m_trunc = '0;
  logic [15:0] eof_seen = '0;
  ent_t        exp_q[$];
  logic [15:0] cur[$];
  logic [15:0] obs_q[$];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, want %h", nm, act, req);
    end
  endtask

  // Expected link words for one stored frame.
  task automatic finalize();
    logic [15:0] acc;
    acc = '0;
    exp_q.push_back('{1'b0, 2'b01, {chan_id, m_seq, 8'hFB}});
    foreach (cur[i]) begin
      exp_q.push_back('{1'b0, 2'b00, cur[i]});
      acc += cur[i];
    end
    if (CS != 0) exp_q.push_back('{1'b0, 2'b00, ~acc});
    exp_q.push_back('{1'b1, 2'b01, {8'(cur.size()), 8'hFD}});
    m_seq++;
    cur.delete();
    last_cyc = cyc;
  endtask

  always @(negedge clk) begin
    ent_t e;
    bit   idle_w;
    idle_w = (tx_charisk == 2'b01) && (tx_data == 16'hB5BC);
    if (rst_pend) begin
      check("rst_tx", 32'({tx_charisk, tx_data}), 32'h1B5BC);
      check("rst_frames", 32'(frames_sent), 0);
      check("rst_trunc", 32'(trunc_cnt), 0);
      if (rst) check("rst_ready", 32'(s_ready), 0);
    end else begin
      check("frames_sent", 32'(frames_sent), 32'(eof_seen));
      check("trunc_cnt", 32'(trunc_cnt), 32'(m_trunc));
      if (in_frame || !idle_w) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %h/%b, want IDLE",
                   tx_data, tx_charisk);
        end else begin
          e = exp_q.pop_front();
          check("tx_word", 32'({tx_charisk, tx_data}), 32'({e.k, e.d}));
          if (!in_frame) begin
            sof_cyc = cyc;
            if (!fresh) check("idle_gap", 32'(idle_run >= GAP), 1);
          end
          obs_q.push_back(tx_data);
          in_frame = !e.eof;
          if (e.eof) begin
            eof_seen++;
            idle_run = 0;
            fresh = 1'b0;
          end
        end
      end else begin
        idle_run++;
      end
    end
    rst_pend = rst;
    if (rst) begin
      exp_q.delete();
      cur.delete();
      discarding = 1'b0;
      in_frame = 1'b0;
      fresh = 1'b1;
      idle_run = 0;
      m_seq = '0;
      m_trunc = '0;
      eof_seen = '0;
    end else if (s_valid && s_ready) begin
      acc_total++;
      if (discarding) begin
        if (s_last) discarding = 1'b0;
      end else begin
        cur.push_back(s_data);
        if (s_last || cur.size() == MAXW) begin
          if (!s_last) begin
            discarding = 1'b1;
            if (m_trunc != 8'hFF) m_trunc++;
          end
          finalize();
        end
      end
    end
    cyc++;
  end

  task automatic put_word(input logic [15:0] d, input logic l);
    int w;
    w = 0;
    s_data  = d;
    s_last  = l;
    s_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      w++;
      if (w > 5000) begin
        tests++;
        fails++;
        $display("FAIL put_word_timeout: got stalled, want accept");
        break;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      put_word(16'($urandom), i == n - 1);
    end
  endtask

  task automatic wait_idle(input string nm);
    int w;
    w = 0;
    while ((exp_q.size() != 0 || in_frame) && w < 20000) begin
      @(posedge clk);
      w++;
    end
    check(nm, 32'(w < 20000), 1);
    repeat (GAP + 4) @(posedge clk);
    #1;
  endtask

  bit rdone;
  int base;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: idle link after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t1_ready", 32'(s_ready), 1);
      check("t1_idle", 32'({tx_charisk, tx_data}), 32'h1B5BC);
    end
    @(posedge clk);
    #1;

    // 2: three-word frame, literal link words
    chan_id = 2'd2;
    obs_q.delete();
    put_word(16'h1111, 1'b0);
    put_word(16'h2222, 1'b0);
    put_word(16'h3333, 1'b1);
    wait_idle("t2_done");
    check("t2_latency", 32'(sof_cyc - last_cyc), 2);
    check("t2_sof", 32'(obs_q[0]), 32'h80FB);
    check("t2_d0", 32'(obs_q[1]), 32'h1111);
    check("t2_d2", 32'(obs_q[3]), 32'h3333);
    check("t2_eof", 32'(obs_q[4 + CS]), 32'h03FD);
    check("t2_frames", 32'(frames_sent), 1);
    put_word(16'h4444, 1'b1);
    wait_idle("t2b_done");
    check("t2_sof2", 32'(obs_q[5 + CS]), 32'h81FB);

    // 3: truncation of a 70-word frame
    chan_id = 2'd3;
    obs_q.delete();
    for (int i = 0; i < 70; i++) put_word(16'(i + 1), i == 69);
    wait_idle("t3_done");
    check("t3_len", 32'(obs_q.size()), 32'(62 + CS));
    check("t3_eof", 32'(obs_q[61 + CS]), 32'h3CFD);
    check("t3_trunc", 32'(trunc_cnt), 1);
    send_frame(4, 1'b0);
    wait_idle("t3b_done");

    // 4: link not ready holds two stored frames
    gtp_ready = 1'b0;
    obs_q.delete();
    send_frame(5, 1'b0);
    send_frame(7, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("t4_hold", 32'(obs_q.size()), 0);
    gtp_ready = 1'b1;
    wait_idle("t4_done");
    check("t4_words", 32'(obs_q.size()), 32'(16 + 2 * CS));

    // 5: fill FIFO, then drain with tx running
    gtp_ready = 1'b0;
    base = acc_total;
    fork
      for (int f = 0; f < 5; f++) send_frame(MAXW, 1'b0);
      begin
        repeat (120) @(posedge clk);
        #1;
        check("t5_fill", 32'(acc_total - base), 64);
        check("t5_full", 32'(s_ready), 0);
        gtp_ready = 1'b1;
      end
    join
    wait_idle("t5_done");
    obs_q.delete();
    repeat (50) @(posedge clk);
    #1;
    check("t5_quiet", 32'(obs_q.size()), 0);

    // 6: reset in the middle of a frame
    send_frame(10, 1'b0);
    begin
      int w;
      w = 0;
      while (w < 300) begin
        @(negedge clk);
        if (tx_charisk == 2'b00) break;
        w++;
      end
      check("t6_reach_data", 32'(w < 300), 1);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chan_id = 2'd1;
    obs_q.delete();
    send_frame(2, 1'b0);
    wait_idle("t6_done");
    check("t6_sof", 32'(obs_q[0]), 32'h40FB);
    check("t6_words", 32'(obs_q.size()), 32'(4 + CS));

    // randomized frames, gaps and link-ready drops
    chan_id = 2'd2;
    rdone = 1'b0;
    fork
      begin
        for (int f = 0; f < 40; f++) send_frame($urandom_range(1, 75), 1'b1);
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(posedge clk);
          #1;
          if ($urandom_range(0, 19) == 0) gtp_ready = ~gtp_ready;
        end
        gtp_ready = 1'b1;
      end
    join
    wait_idle("rand_done");
    check("rand_trunc", 32'(trunc_cnt), 32'(m_trunc));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #(8 * 90000);
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

endmodule
